// File: rtl/lsu_ctr.sv
// Load/store controller sitting between the execute unit and a valid/ready
// command/response data bus. Handles one request at a time. A bus timeout
// and a drain of late responses keep a stalled bus from hanging the core.
module lsu_ctr #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ex4ls_val,
    output logic        hs_ls4ex_rdy,
    input  logic [31:0] i_ls_adr,
    input  logic [31:0] i_ls_wdat,
    input  logic [3:0]  i_ls_wen,
    input  logic        i_ls_ren,
    output logic [31:0] o_ls_rdat,
    output logic        o_ls_err,
    output logic        o_bus_cmd_val,
    input  logic        i_bus_cmd_rdy,
    output logic [31:0] o_bus_cmd_adr,
    output logic        o_bus_cmd_read,
    output logic [31:0] o_bus_cmd_wdat,
    output logic [3:0]  o_bus_cmd_wmask,
    input  logic        i_bus_rsp_val,
    output logic        o_bus_rsp_rdy,
    input  logic [31:0] i_bus_rsp_rdat,
    input  logic        i_bus_rsp_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RSP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Last count value before abort; only meaningful when the timeout is enabled.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic             TMO_EN   = (TMO_CYC != 0);

    state_t            state_r, state_s;
    logic [31:0]       adr_r, adr_s;
    logic [31:0]       wdat_r, wdat_s;
    logic [3:0]        wmask_r, wmask_s;
    logic              read_r, read_s;
    logic [TMO_W-1:0]  cnt_r, cnt_s;
    logic              stale_r, stale_s;
    logic [31:0]       rdat_r, rdat_s;
    logic              err_r, err_s;
    logic              cmd_val_r;
    logic              rsp_rdy_r;
    logic              ls_rdy_r;
    logic [TMO_W-1:0]  cnt_inc_s;
    logic              expire_s;

    // Saturating increment and expiry decode of the timeout counter.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r != {TMO_W{1'b1}}) begin
            cnt_inc_s = cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_inc_s = cnt_r;
        end
        expire_s = TMO_EN && (cnt_r == TMO_LAST);
    end

    // Next-state and next-datapath decode for the transaction FSM.
    always_comb begin
        state_s = state_r;
        adr_s   = adr_r;
        wdat_s  = wdat_r;
        wmask_s = wmask_r;
        read_s  = read_r;
        cnt_s   = cnt_r;
        stale_s = stale_r;
        rdat_s  = rdat_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_ex4ls_val) begin
                    if (i_ls_wen != 4'b0000) begin
                        // Store takes priority when both enables are set.
                        adr_s   = {i_ls_adr[31:2], 2'b00};
                        wdat_s  = i_ls_wdat;
                        wmask_s = i_ls_wen;
                        read_s  = 1'b0;
                        cnt_s   = {TMO_W{1'b0}};
                        state_s = ST_CMD;
                    end else if (i_ls_ren) begin
                        adr_s   = {i_ls_adr[31:2], 2'b00};
                        wdat_s  = i_ls_wdat;
                        wmask_s = i_ls_wen;
                        read_s  = 1'b1;
                        cnt_s   = {TMO_W{1'b0}};
                        state_s = ST_CMD;
                    end else begin
                        // Neither load nor store: complete immediately.
                        rdat_s  = 32'h0000_0000;
                        err_s   = 1'b0;
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                cnt_s = cnt_inc_s;
                if (i_bus_cmd_rdy) begin
                    state_s = ST_RSP;
                end else if (expire_s) begin
                    rdat_s  = 32'h0000_0000;
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_RSP: begin
                cnt_s = cnt_inc_s;
                if (i_bus_rsp_val) begin
                    rdat_s  = read_r ? i_bus_rsp_rdat : 32'h0000_0000;
                    err_s   = i_bus_rsp_err;
                    state_s = ST_DONE;
                end else if (expire_s) begin
                    // The response may still arrive later; remember to drain it.
                    rdat_s  = 32'h0000_0000;
                    err_s   = 1'b1;
                    stale_s = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            ST_DONE: begin
                if (stale_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_bus_rsp_val) begin
                    stale_s = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request fields and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            adr_r     <= 32'h0000_0000;
            wdat_r    <= 32'h0000_0000;
            wmask_r   <= 4'b0000;
            read_r    <= 1'b0;
            cnt_r     <= {TMO_W{1'b0}};
            stale_r   <= 1'b0;
            rdat_r    <= 32'h0000_0000;
            err_r     <= 1'b0;
            cmd_val_r <= 1'b0;
            rsp_rdy_r <= 1'b0;
            ls_rdy_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            adr_r     <= adr_s;
            wdat_r    <= wdat_s;
            wmask_r   <= wmask_s;
            read_r    <= read_s;
            cnt_r     <= cnt_s;
            stale_r   <= stale_s;
            rdat_r    <= rdat_s;
            err_r     <= err_s;
            cmd_val_r <= (state_s == ST_CMD);
            rsp_rdy_r <= (state_s == ST_RSP) || (state_s == ST_DRAIN);
            ls_rdy_r  <= (state_s == ST_DONE);
        end
    end

    assign hs_ls4ex_rdy    = ls_rdy_r;
    assign o_ls_rdat       = rdat_r;
    assign o_ls_err        = err_r;
    assign o_bus_cmd_val   = cmd_val_r;
    assign o_bus_cmd_adr   = adr_r;
    assign o_bus_cmd_read  = read_r;
    assign o_bus_cmd_wdat  = wdat_r;
    assign o_bus_cmd_wmask = wmask_r;
    assign o_bus_rsp_rdy   = rsp_rdy_r;

endmodule

// File: tb/tb_lsu_ctr.sv
// Directed bench for lsu_ctr. Two instances share all inputs: dut_a uses the
// default timeout, dut_t uses TMO_CYC=4 for the timeout scenarios.
module tb_lsu_ctr;

    logic        clk;
    logic        rst;
    logic        val;
    logic [31:0] ls_adr;
    logic [31:0] ls_wdat;
    logic [3:0]  ls_wen;
    logic        ls_ren;
    logic        cmd_rdy;
    logic        rsp_val;
    logic [31:0] rsp_rdat;
    logic        rsp_err;

    logic        a_rdy, a_err, a_cmd_val, a_read, a_rsp_rdy;
    logic [31:0] a_rdat, a_adr, a_wdat;
    logic [3:0]  a_wmask;
    logic        t_rdy, t_err, t_cmd_val, t_read, t_rsp_rdy;
    logic [31:0] t_rdat, t_adr, t_wdat;
    logic [3:0]  t_wmask;

    int checks = 0;
    int errors = 0;

    lsu_ctr dut_a (
        .clk(clk), .rst(rst),
        .hs_ex4ls_val(val), .hs_ls4ex_rdy(a_rdy),
        .i_ls_adr(ls_adr), .i_ls_wdat(ls_wdat), .i_ls_wen(ls_wen), .i_ls_ren(ls_ren),
        .o_ls_rdat(a_rdat), .o_ls_err(a_err),
        .o_bus_cmd_val(a_cmd_val), .i_bus_cmd_rdy(cmd_rdy),
        .o_bus_cmd_adr(a_adr), .o_bus_cmd_read(a_read),
        .o_bus_cmd_wdat(a_wdat), .o_bus_cmd_wmask(a_wmask),
        .i_bus_rsp_val(rsp_val), .o_bus_rsp_rdy(a_rsp_rdy),
        .i_bus_rsp_rdat(rsp_rdat), .i_bus_rsp_err(rsp_err)
    );

    lsu_ctr #(.TMO_W(8), .TMO_CYC(4)) dut_t (
        .clk(clk), .rst(rst),
        .hs_ex4ls_val(val), .hs_ls4ex_rdy(t_rdy),
        .i_ls_adr(ls_adr), .i_ls_wdat(ls_wdat), .i_ls_wen(ls_wen), .i_ls_ren(ls_ren),
        .o_ls_rdat(t_rdat), .o_ls_err(t_err),
        .o_bus_cmd_val(t_cmd_val), .i_bus_cmd_rdy(cmd_rdy),
        .o_bus_cmd_adr(t_adr), .o_bus_cmd_read(t_read),
        .o_bus_cmd_wdat(t_wdat), .o_bus_cmd_wmask(t_wmask),
        .i_bus_rsp_val(rsp_val), .o_bus_rsp_rdy(t_rsp_rdy),
        .i_bus_rsp_rdat(rsp_rdat), .i_bus_rsp_err(rsp_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        val      = 1'b0;
        ls_adr   = 32'h0000_0000;
        ls_wdat  = 32'h0000_0000;
        ls_wen   = 4'b0000;
        ls_ren   = 1'b0;
        cmd_rdy  = 1'b0;
        rsp_val  = 1'b0;
        rsp_rdat = 32'h0000_0000;
        rsp_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_cmd_val", {31'd0, a_cmd_val}, 32'd0);
        chk("rst_rsp_rdy", {31'd0, a_rsp_rdy}, 32'd0);
        chk("rst_ls_rdy",  {31'd0, a_rdy},     32'd0);
        chk("rst_rdat",    a_rdat,             32'd0);
        rst = 1'b0;

        // Load with immediate bus handshakes.
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_1004;
        cmd_rdy = 1'b1; rsp_val = 1'b1; rsp_rdat = 32'hDEAD_BEEF;
        step();
        val = 1'b0;
        chk("ld_cmd_val", {31'd0, a_cmd_val}, 32'd1);
        chk("ld_cmd_adr", a_adr, 32'h0000_1004);
        chk("ld_cmd_read", {31'd0, a_read}, 32'd1);
        chk("ld_rdy_early", {31'd0, a_rdy}, 32'd0);
        step();
        chk("ld_rsp_rdy", {31'd0, a_rsp_rdy}, 32'd1);
        chk("ld_cmd_val_off", {31'd0, a_cmd_val}, 32'd0);
        step();
        chk("ld_rdy", {31'd0, a_rdy}, 32'd1);
        chk("ld_rdat", a_rdat, 32'hDEAD_BEEF);
        chk("ld_err", {31'd0, a_err}, 32'd0);
        idle_inputs();
        step();
        chk("ld_rdy_pulse", {31'd0, a_rdy}, 32'd0);

        // Store (ren also set, store wins) with command accepted after 5 waits.
        do_reset();
        val = 1'b1; ls_adr = 32'h0000_2002; ls_wdat = 32'h1234_5678;
        ls_wen = 4'b1100; ls_ren = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            chk("st_cmd_val", {31'd0, a_cmd_val}, 32'd1);
            chk("st_cmd_adr", a_adr, 32'h0000_2000);
            chk("st_cmd_wdat", a_wdat, 32'h1234_5678);
            chk("st_cmd_wmask", {28'd0, a_wmask}, 32'h0000_000C);
            chk("st_cmd_read", {31'd0, a_read}, 32'd0);
            if (i == 5) cmd_rdy = 1'b1;
            step();
        end
        cmd_rdy = 1'b0;
        chk("st_cmd_val_off", {31'd0, a_cmd_val}, 32'd0);
        chk("st_rsp_rdy", {31'd0, a_rsp_rdy}, 32'd1);
        rsp_val = 1'b1; rsp_rdat = 32'hFFFF_FFFF;
        step();
        rsp_val = 1'b0;
        chk("st_rdy", {31'd0, a_rdy}, 32'd1);
        chk("st_rdat", a_rdat, 32'd0);
        chk("st_err", {31'd0, a_err}, 32'd0);
        step();

        // Command-phase timeout on the TMO_CYC=4 instance.
        do_reset();
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_3000;
        step();
        val = 1'b0; ls_ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tc_cmd_val", {31'd0, t_cmd_val}, 32'd1);
            chk("tc_rdy_early", {31'd0, t_rdy}, 32'd0);
            step();
        end
        chk("tc_cmd_val_drop", {31'd0, t_cmd_val}, 32'd0);
        chk("tc_rdy", {31'd0, t_rdy}, 32'd1);
        chk("tc_err", {31'd0, t_err}, 32'd1);
        chk("tc_rdat", t_rdat, 32'd0);
        step();
        chk("tc_cmd_val_after", {31'd0, t_cmd_val}, 32'd0);
        chk("tc_rsp_rdy_after", {31'd0, t_rsp_rdy}, 32'd0);
        chk("tc_rdy_after", {31'd0, t_rdy}, 32'd0);

        // Response-phase timeout, drain of the late response, then a new load.
        do_reset();
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_4000; cmd_rdy = 1'b1;
        step();
        val = 1'b0;
        chk("tr_cmd_val", {31'd0, t_cmd_val}, 32'd1);
        step();
        cmd_rdy = 1'b0;
        chk("tr_rsp_rdy", {31'd0, t_rsp_rdy}, 32'd1);
        step();
        step();
        step();
        chk("tr_rdy", {31'd0, t_rdy}, 32'd1);
        chk("tr_err", {31'd0, t_err}, 32'd1);
        chk("tr_rdat", t_rdat, 32'd0);
        val = 1'b1; ls_adr = 32'h0000_5000;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("tr_drain_rsp_rdy", {31'd0, t_rsp_rdy}, 32'd1);
            chk("tr_drain_no_cmd", {31'd0, t_cmd_val}, 32'd0);
            chk("tr_drain_no_rdy", {31'd0, t_rdy}, 32'd0);
            step();
        end
        rsp_val = 1'b1; rsp_rdat = 32'hBAD0_BAD0;
        step();
        rsp_val = 1'b0;
        chk("tr_idle_rsp_rdy", {31'd0, t_rsp_rdy}, 32'd0);
        chk("tr_idle_cmd_val", {31'd0, t_cmd_val}, 32'd0);
        step();
        val = 1'b0;
        chk("tr_new_cmd_val", {31'd0, t_cmd_val}, 32'd1);
        chk("tr_new_cmd_adr", t_adr, 32'h0000_5000);
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        rsp_val = 1'b1; rsp_rdat = 32'h600D_F00D;
        step();
        rsp_val = 1'b0;
        chk("tr_new_rdy", {31'd0, t_rdy}, 32'd1);
        chk("tr_new_rdat", t_rdat, 32'h600D_F00D);
        chk("tr_new_err", {31'd0, t_err}, 32'd0);
        step();

        // Load with bus error response.
        do_reset();
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_6008;
        cmd_rdy = 1'b1; rsp_val = 1'b1; rsp_err = 1'b1; rsp_rdat = 32'hCAFE_0001;
        step();
        val = 1'b0;
        step();
        step();
        chk("be_rdy", {31'd0, a_rdy}, 32'd1);
        chk("be_err", {31'd0, a_err}, 32'd1);
        chk("be_rdat", a_rdat, 32'hCAFE_0001);
        idle_inputs();
        step();

        // Request with neither load nor store completes as a no-op.
        val = 1'b1;
        step();
        val = 1'b0;
        chk("nop_rdy", {31'd0, a_rdy}, 32'd1);
        chk("nop_cmd_val", {31'd0, a_cmd_val}, 32'd0);
        chk("nop_rdat", a_rdat, 32'd0);
        chk("nop_err", {31'd0, a_err}, 32'd0);
        step();

        // Reset while waiting for a response, then a normal load.
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_7000; cmd_rdy = 1'b1;
        step();
        val = 1'b0;
        step();
        cmd_rdy = 1'b0;
        chk("rr_rsp_rdy", {31'd0, a_rsp_rdy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_rsp_rdy_0", {31'd0, a_rsp_rdy}, 32'd0);
        chk("rr_cmd_val_0", {31'd0, a_cmd_val}, 32'd0);
        chk("rr_rdy_0", {31'd0, a_rdy}, 32'd0);
        chk("rr_adr_0", a_adr, 32'd0);
        chk("rr_read_0", {31'd0, a_read}, 32'd0);
        val = 1'b1; ls_ren = 1'b1; ls_adr = 32'h0000_8004;
        cmd_rdy = 1'b1; rsp_val = 1'b1; rsp_rdat = 32'h1111_2222;
        step();
        val = 1'b0;
        chk("rr_ld_cmd_adr", a_adr, 32'h0000_8004);
        step();
        step();
        chk("rr_ld_rdy", {31'd0, a_rdy}, 32'd1);
        chk("rr_ld_rdat", a_rdat, 32'h1111_2222);
        chk("rr_ld_err", {31'd0, a_err}, 32'd0);
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctr.md
Name: lsu_ctr

Overview:
- Load/store controller directly downstream of the execute unit.
- Accepts one memory request at a time over the execute unit's load/store handshake (address, write data, byte write-enable, read-enable).
- Issues the request on a valid/ready command/response data bus and returns read data or completion to the execute unit.
- Adds a bus timeout, an error flag, and a drain of late responses so a stalled bus cannot hang the core.

Parameters:
- TMO_W, 8, width of the timeout counter.
- TMO_CYC, 255, cycles allowed in CMD+RSP before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- hs_ex4ls_val  in  1  request valid from execute unit
- hs_ls4ex_rdy  out  1  one-cycle completion pulse to execute unit
- i_ls_adr  in  32  byte address
- i_ls_wdat  in  32  write data
- i_ls_wen  in  4  byte write enables; nonzero means store
- i_ls_ren  in  1  load request
- o_ls_rdat  out  32  load data, valid while hs_ls4ex_rdy=1
- o_ls_err  out  1  bus error or timeout, valid while hs_ls4ex_rdy=1
- o_bus_cmd_val  out  1  command valid
- i_bus_cmd_rdy  in  1  command accepted
- o_bus_cmd_adr  out  32  command address, word-aligned (adr[1:0] forced to 0)
- o_bus_cmd_read  out  1  1=read, 0=write
- o_bus_cmd_wdat  out  32  write data
- o_bus_cmd_wmask  out  4  byte mask
- i_bus_rsp_val  in  1  response valid
- o_bus_rsp_rdy  out  1  response ready
- i_bus_rsp_rdat  in  32  response data
- i_bus_rsp_err  in  1  response error

Behaviour:
- States: IDLE, CMD, RSP, DONE, DRAIN.
- All outputs are registered or decoded from state and latched registers; no combinational path from bus inputs to execute-side outputs.
- Reset (sampled high at an edge): state←IDLE; all outputs and latched registers←0; timeout counter←0; stale flag←0. This applies mid-transaction: an outstanding bus command or response is abandoned, and cmd_val drops in the cycle after reset.
- IDLE:
  - hs_ex4ls_val=1 with wen≠0: latch adr/wdat/wen, read=0, go to CMD. A store wins if ren is also set.
  - hs_ex4ls_val=1 with wen=0 and ren=1: latch, read=1, go to CMD.
  - hs_ex4ls_val=1 with neither: no-op; go to DONE with rdat=0, err=0.
  - Request inputs are sampled only in IDLE; changes in any other state are ignored.
- CMD: o_bus_cmd_val=1 with latched fields held stable. On i_bus_cmd_rdy go to RSP; the counter continues.
- RSP: o_bus_rsp_rdy=1. On i_bus_rsp_val capture rdat (forced to 0 for writes), set err=i_bus_rsp_err, go to DONE.
- Timeout counter:
  - Cleared on IDLE→CMD; increments every cycle in CMD and RSP; saturates.
  - When TMO_CYC≠0 and count==TMO_CYC-1 with no handshake that cycle:
    - In CMD: drop cmd_val; go to DONE with err=1, rdat=0.
    - In RSP: go to DONE with err=1, rdat=0, and set the stale flag.
  - A handshake in the same cycle as expiry wins.
- DONE: hs_ls4ex_rdy=1, o_ls_rdat/o_ls_err valid, for exactly one cycle. hs_ex4ls_val is ignored. Next state is DRAIN if the stale flag is set, else IDLE.
- DRAIN: o_bus_rsp_rdy=1; hs_ex4ls_val is ignored. On i_bus_rsp_val discard the data, clear the stale flag, go to IDLE.
- Execute unit obligation: deassert hs_ex4ls_val, or present a new request, in the cycle after hs_ls4ex_rdy. A val still high in IDLE starts a new transaction.
- Minimum latency: val sampled at cycle 0 → cmd_val at cycle 1 → (cmd_rdy at 1) response accepted at cycle 2 → rdy at cycle 3. Throughput is one request per 4 cycles.
- Responses arriving in IDLE, CMD or DONE are not accepted (rsp_rdy=0).

Test Plan:
- Load 0x0000_1004, bus cmd_rdy and rsp_val immediate with rdat 0xDEAD_BEEF → cmd_adr=0x0000_1004, read=1; rdy at cycle 3 with rdat=0xDEAD_BEEF, err=0.
- Store adr 0x2002, wdat 0x1234_5678, wen=4'b1100 with cmd_rdy delayed 5 cycles → cmd fields stable for 6 cycles, adr=0x2000, wmask=1100; rdy with rdat=0, err=0.
- TMO_CYC=4, cmd_rdy held 0 → cmd_val high exactly 4 cycles, then rdy with err=1; cmd_val=0 afterwards.
- TMO_CYC=4, cmd accepted, response arrives 10 cycles later → rdy with err=1, then DRAIN holds rsp_rdy=1 until the response, which is discarded; a new request is only accepted after return to IDLE.
- Response with i_bus_rsp_err=1 on a load → rdy with err=1, rdat=captured bus data.
- rst asserted in RSP → next cycle all outputs 0, state IDLE; a subsequent load completes normally.
